// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_ctrl
// Description : Command sequencer behind the TDC UART receiver.
//               - Free-running divider producing the 16x oversample enable
//                 tick (rx_enable_o) that paces the receiver.
//               - Collects received bytes into fixed-length frames
//                 (SYNC, CMD, DATA[, CSUM]), validates them, and either
//                 writes a configuration register or issues a measurement
//                 start/stop strobe.
//               - Malformed or stalled frames are discarded, signalled on
//                 frame_err_o and counted (saturating) in err_count_o.
//
// Build option: UART_CMD_CSUM_EN
//               defined   : 4-byte frames, CSUM = CMD ^ DATA is checked.
//               undefined : 3-byte frames, no checksum state.
//
// Parameters  : CLK_DIV   system clocks per oversample tick (>= 2)
//               TIMEOUT   oversample ticks allowed between frame bytes
//                         (16-bit, >= 1)
//               SYNC_BYTE frame start marker
//
// Ports       : clk_i          in   1  system clock, rising edge
//               rst_ni         in   1  asynchronous active-low reset
//               rx_enable_o    out  1  one-cycle oversample tick
//               rx_byte_i      in   8  received byte
//               rx_byte_rdy_i  in   1  one-cycle byte-valid pulse
//               cfg_addr_o     out  7  configuration register address
//               cfg_data_o     out  8  configuration write data
//               cfg_we_o       out  1  one-cycle configuration write strobe
//               meas_start_o   out  1  one-cycle measurement start strobe
//               meas_stop_o    out  1  one-cycle measurement stop strobe
//               busy_o         out  1  frame in progress (state != IDLE)
//               frame_err_o    out  1  one-cycle pulse per discarded frame
//               err_count_o    out  8  saturating discarded-frame count
//
// Revision    : 1.0  initial release
// ============================================================================
module uart_cmd_ctrl #(
    parameter int unsigned CLK_DIV   = 27,
    parameter int unsigned TIMEOUT   = 4096,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    output logic       rx_enable_o,
    input  logic [7:0] rx_byte_i,
    input  logic       rx_byte_rdy_i,
    output logic [6:0] cfg_addr_o,
    output logic [7:0] cfg_data_o,
    output logic       cfg_we_o,
    output logic       meas_start_o,
    output logic       meas_stop_o,
    output logic       busy_o,
    output logic       frame_err_o,
    output logic [7:0] err_count_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int unsigned   DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);
    // The timeout fires on the tick that would bring the count to TIMEOUT,
    // so the comparison is against TIMEOUT-1 before incrementing.
    localparam logic [15:0]   C_TO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [7:0]    C_ACT_START = 8'h80;
    localparam logic [7:0]    C_ACT_STOP  = 8'h81;

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GET_CMD  = 3'd1,
        S_GET_DATA = 3'd2,
`ifdef UART_CMD_CSUM_EN
        S_GET_CSUM = 3'd3,
`endif
        S_EXEC     = 3'd4
    } state_e;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [DIV_W-1:0] div_q;
    logic             w_tick;

    state_e           state_q, state_d;
    logic [15:0]      to_q, to_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [7:0]       data_q, data_d;

    logic             w_collecting;
    logic             w_err;
    logic             w_we;
    logic             w_start;
    logic             w_stop;

    logic [6:0]       cfg_addr_q;
    logic [7:0]       cfg_data_q;
    logic             cfg_we_q;
    logic             meas_start_q;
    logic             meas_stop_q;
    logic             frame_err_q;
    logic [7:0]       err_count_q;

    // ------------------------------------------------------------------------
    // Oversample tick divider: counts 0..CLK_DIV-1 and wraps.
    // ------------------------------------------------------------------------
    assign w_tick = (div_q == C_DIV_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q <= '0;
        end else if (w_tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Frame FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            to_q    <= '0;
            cmd_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            to_q    <= to_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
        end
    end

    // ------------------------------------------------------------------------
    // Frame FSM: next state and decoded actions
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        to_d         = to_q;
        cmd_d        = cmd_q;
        data_d       = data_q;
        w_collecting = 1'b0;
        w_err        = 1'b0;
        w_we         = 1'b0;
        w_start      = 1'b0;
        w_stop       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Non-sync bytes are dropped without raising an error.
                if (rx_byte_rdy_i && (rx_byte_i == SYNC_BYTE)) begin
                    state_d = S_GET_CMD;
                    to_d    = '0;
                end
            end

            S_GET_CMD: begin
                w_collecting = 1'b1;
                if (rx_byte_rdy_i) begin
                    cmd_d   = rx_byte_i;
                    to_d    = '0;
                    state_d = S_GET_DATA;
                end
            end

            S_GET_DATA: begin
                w_collecting = 1'b1;
                if (rx_byte_rdy_i) begin
                    data_d  = rx_byte_i;
                    to_d    = '0;
`ifdef UART_CMD_CSUM_EN
                    state_d = S_GET_CSUM;
`else
                    state_d = S_EXEC;
`endif
                end
            end

`ifdef UART_CMD_CSUM_EN
            S_GET_CSUM: begin
                w_collecting = 1'b1;
                if (rx_byte_rdy_i) begin
                    to_d = '0;
                    if (rx_byte_i == (cmd_q ^ data_q)) begin
                        state_d = S_EXEC;
                    end else begin
                        w_err   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
`endif

            S_EXEC: begin
                // Single-cycle state; a byte arriving here is ignored.
                state_d = S_IDLE;
                to_d    = '0;
                if (!cmd_q[7]) begin
                    w_we = 1'b1;
                end else if (cmd_q == C_ACT_START) begin
                    w_start = 1'b1;
                end else if (cmd_q == C_ACT_STOP) begin
                    w_stop = 1'b1;
                end else begin
                    w_err = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                to_d    = '0;
            end
        endcase

        // Inter-byte timeout. A byte in the same cycle as the expiring tick
        // takes precedence (handled above, which also clears the counter).
        if (w_collecting && !rx_byte_rdy_i && w_tick) begin
            if (to_q == C_TO_LAST) begin
                w_err   = 1'b1;
                state_d = S_IDLE;
                to_d    = '0;
            end else begin
                to_d = to_q + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registered strobes, configuration outputs and error counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_addr_q   <= '0;
            cfg_data_q   <= '0;
            cfg_we_q     <= 1'b0;
            meas_start_q <= 1'b0;
            meas_stop_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            err_count_q  <= '0;
        end else begin
            cfg_we_q     <= w_we;
            meas_start_q <= w_start;
            meas_stop_q  <= w_stop;
            frame_err_q  <= w_err;
            // Address/data hold their value until the next register write.
            if (w_we) begin
                cfg_addr_q <= cmd_q[6:0];
                cfg_data_q <= data_q;
            end
            if (w_err && (err_count_q != 8'hFF)) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rx_enable_o  = w_tick;
    assign busy_o       = (state_q != S_IDLE);
    assign cfg_addr_o   = cfg_addr_q;
    assign cfg_data_o   = cfg_data_q;
    assign cfg_we_o     = cfg_we_q;
    assign meas_start_o = meas_start_q;
    assign meas_stop_o  = meas_stop_q;
    assign frame_err_o  = frame_err_q;
    assign err_count_o  = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_ctrl
// Description : Self-checking bench for uart_cmd_ctrl. A frame-level
//               reference model (byte queue + tick counter) predicts every
//               output each cycle; a vector table covers the directed frames
//               and hand-written sequences cover timeout, saturation, stray
//               bytes, tick period and mid-frame reset. Honours
//               UART_CMD_CSUM_EN in the same way as the design.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_cmd_ctrl;

    localparam int         CLK_DIV = 4;
    localparam int         TIMEOUT = 8;
    localparam logic [7:0] SYNC    = 8'hA5;
`ifdef UART_CMD_CSUM_EN
    localparam int FLEN = 4;
    localparam bit CSUM = 1'b1;
`else
    localparam int FLEN = 3;
    localparam bit CSUM = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       rx_enable;
    logic [7:0] rx_byte;
    logic       rx_byte_rdy;
    logic [6:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       cfg_we;
    logic       meas_start;
    logic       meas_stop;
    logic       busy;
    logic       frame_err;
    logic [7:0] err_count;

    uart_cmd_ctrl #(
        .CLK_DIV  (CLK_DIV),
        .TIMEOUT  (TIMEOUT),
        .SYNC_BYTE(SYNC)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rx_enable_o  (rx_enable),
        .rx_byte_i    (rx_byte),
        .rx_byte_rdy_i(rx_byte_rdy),
        .cfg_addr_o   (cfg_addr),
        .cfg_data_o   (cfg_data),
        .cfg_we_o     (cfg_we),
        .meas_start_o (meas_start),
        .meas_stop_o  (meas_stop),
        .busy_o       (busy),
        .frame_err_o  (frame_err),
        .err_count_o  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    int         mdiv;
    int         mto;
    logic [7:0] mframe[$];
    bit         mexec;
    bit         exp_we, exp_start, exp_stop, exp_ferr;
    logic [6:0] exp_addr;
    logic [7:0] exp_data;
    int         exp_cnt;

    function automatic void model_reset();
        mdiv = 0; mto = 0; mframe.delete(); mexec = 1'b0;
        exp_we = 0; exp_start = 0; exp_stop = 0; exp_ferr = 0;
        exp_addr = '0; exp_data = '0; exp_cnt = 0;
    endfunction

    function automatic void model_step(bit rdy, logic [7:0] b);
        bit tick;
        bit err;
        logic [7:0] c;
        tick = (mdiv == CLK_DIV - 1);
        err = 1'b0;
        exp_we = 0; exp_start = 0; exp_stop = 0;
        if (mexec) begin
            c = mframe[1];
            if (!c[7]) begin
                exp_we = 1; exp_addr = c[6:0]; exp_data = mframe[2];
            end else if (c == 8'h80) exp_start = 1;
            else if (c == 8'h81) exp_stop = 1;
            else err = 1'b1;
            mexec = 1'b0;
            mframe.delete();
        end else if (mframe.size() == 0) begin
            if (rdy && b == SYNC) begin mframe.push_back(b); mto = 0; end
        end else if (rdy) begin
            mframe.push_back(b);
            mto = 0;
            if (mframe.size() == FLEN) begin
                if (CSUM && (mframe[FLEN-1] != (mframe[1] ^ mframe[2]))) begin
                    err = 1'b1; mframe.delete();
                end else mexec = 1'b1;
            end
        end else if (tick) begin
            mto++;
            if (mto == TIMEOUT) begin err = 1'b1; mframe.delete(); end
        end
        exp_ferr = err;
        if (err && exp_cnt < 255) exp_cnt++;
        mdiv = (mdiv + 1) % CLK_DIV;
    endfunction

    // ---------------- bookkeeping ----------------
    int cyc = 0;
    int last_we_cyc;
    int acc_we, acc_start, acc_stop, acc_err, acc_busy;
    bit s_rx_en, s_busy, s_ferr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clr_acc();
        acc_we = 0; acc_start = 0; acc_stop = 0; acc_err = 0; acc_busy = 0;
        last_we_cyc = -100;
    endtask

    // Called at a falling edge: compare, drive, advance the model, move on.
    task automatic cycle(input bit rdy, input logic [7:0] b);
        logic [28:0] act;
        logic [28:0] exp;
        act = {rx_enable, cfg_we, meas_start, meas_stop, frame_err, busy,
               cfg_addr, cfg_data, err_count};
        exp = {(mdiv == CLK_DIV - 1), exp_we, exp_start, exp_stop, exp_ferr,
               (mframe.size() != 0), exp_addr, exp_data, exp_cnt[7:0]};
        chk("cycle_model", 64'(act), 64'(exp));
        if (cfg_we) begin acc_we++; last_we_cyc = cyc; end
        if (meas_start) acc_start++;
        if (meas_stop) acc_stop++;
        if (frame_err) acc_err++;
        if (busy) acc_busy++;
        s_rx_en = rx_enable; s_busy = busy; s_ferr = frame_err;
        rx_byte_rdy = rdy;
        rx_byte = b;
        model_step(rdy, b);
        cyc++;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        cycle(1'b1, b);
        repeat (gap) cycle(1'b0, 8'h00);
    endtask

    int last_rdy_cyc;
    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] data,
                              input logic [7:0] csum, input int gap);
        send_byte(SYNC, gap);
        send_byte(cmd, gap);
        if (CSUM) begin
            send_byte(data, gap);
            last_rdy_cyc = cyc;
            send_byte(csum, gap);
        end else begin
            last_rdy_cyc = cyc;
            send_byte(data, gap);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rx_byte_rdy = 1'b0;
        rx_byte = 8'h00;
        #1;
        chk("reset_state", 64'({rx_enable, cfg_we, meas_start, meas_stop, frame_err,
                                busy, cfg_addr, cfg_data, err_count}), 64'd0);
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [7:0] cmd;
        logic [7:0] data;
        logic [7:0] csum;
        bit         we;
        bit         start;
        bit         stop;
        bit         err;
        logic [6:0] addr;
        logic [7:0] dat;
    } vec_t;

    vec_t tbl[6];

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int ticks, k, t1, t2, first;
        bit prev, found;
        int err_before;
        logic [7:0] cmd, data, csum;
        int kind, gap, n;

        tbl[0] = '{8'h12, 8'h3C, 8'h2E, 1, 0, 0, 0, 7'h12, 8'h3C};
        tbl[1] = '{8'h80, 8'h00, 8'h80, 0, 1, 0, 0, 7'h00, 8'h00};
        tbl[2] = '{8'h81, 8'h00, 8'h81, 0, 0, 1, 0, 7'h00, 8'h00};
        tbl[3] = '{8'h85, 8'h00, 8'h85, 0, 0, 0, 1, 7'h00, 8'h00};
`ifdef UART_CMD_CSUM_EN
        tbl[4] = '{8'h12, 8'h3C, 8'h2F, 0, 0, 0, 1, 7'h00, 8'h00};
`else
        tbl[4] = '{8'h12, 8'h3C, 8'h2F, 1, 0, 0, 0, 7'h12, 8'h3C};
`endif
        tbl[5] = '{8'h7F, 8'hC3, 8'hBC, 1, 0, 0, 0, 7'h7F, 8'hC3};

        rst_n = 1'b0;
        rx_byte_rdy = 1'b0;
        rx_byte = 8'h00;
        @(negedge clk);
        do_reset();
        clr_acc();

        // First tick after reset, then the tick period.
        first = -1;
        for (int i = 0; i < CLK_DIV; i++) begin
            cycle(1'b0, 8'h00);
            if (s_rx_en && first < 0) first = i;
        end
        chk("first_tick_index", 64'(first), 64'(CLK_DIV - 1));
        t1 = -1; t2 = -1;
        for (int i = 0; i < 3 * CLK_DIV && t2 < 0; i++) begin
            cycle(1'b0, 8'h00);
            if (s_rx_en) begin
                if (t1 < 0) t1 = i; else t2 = i;
            end
        end
        chk("tick_period", 64'(t2 - t1), 64'(CLK_DIV));

        // Table-driven frames.
        for (int i = 0; i < 6; i++) begin
            clr_acc();
            err_before = err_count;
            send_frame(tbl[i].cmd, tbl[i].data, tbl[i].csum, 3);
            repeat (6) cycle(1'b0, 8'h00);
            chk($sformatf("tbl%0d_we", i), 64'(acc_we), 64'(tbl[i].we));
            chk($sformatf("tbl%0d_start", i), 64'(acc_start), 64'(tbl[i].start));
            chk($sformatf("tbl%0d_stop", i), 64'(acc_stop), 64'(tbl[i].stop));
            chk($sformatf("tbl%0d_err", i), 64'(acc_err), 64'(tbl[i].err));
            chk($sformatf("tbl%0d_errcnt_delta", i), 64'(err_count - err_before),
                64'(tbl[i].err));
            if (tbl[i].we) begin
                chk($sformatf("tbl%0d_addr", i), 64'(cfg_addr), 64'(tbl[i].addr));
                chk($sformatf("tbl%0d_data", i), 64'(cfg_data), 64'(tbl[i].dat));
                chk($sformatf("tbl%0d_we_latency", i), 64'(last_we_cyc - last_rdy_cyc), 64'd2);
            end
        end

        // Stray bytes in IDLE.
        clr_acc();
        send_byte(8'h00, 2);
        send_byte(8'hFF, 2);
        send_byte(8'h5A, 2);
        chk("stray_busy_cycles", 64'(acc_busy), 64'd0);
        chk("stray_err", 64'(acc_err), 64'd0);

        // Timeout: SYNC, CMD and then silence.
        clr_acc();
        send_byte(SYNC, 1);
        cycle(1'b1, 8'h12);
        ticks = 0; prev = 1'b0; found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            cycle(1'b0, 8'h00);
            if (s_ferr) begin
                found = 1'b1;
                chk("timeout_ticks", 64'(ticks), 64'(TIMEOUT));
                chk("timeout_after_tick", 64'(prev), 64'd1);
                chk("timeout_busy", 64'(s_busy), 64'd0);
            end else begin
                ticks += int'(s_rx_en);
                prev = s_rx_en;
            end
        end
        chk("timeout_seen", 64'(found), 64'd1);
        clr_acc();
        send_frame(8'h12, 8'h3C, 8'h2E, 2);
        repeat (5) cycle(1'b0, 8'h00);
        chk("post_timeout_we", 64'(acc_we), 64'd1);
        chk("post_timeout_err", 64'(acc_err), 64'd0);

        // Saturation of the error counter.
        for (int i = 0; i < 257; i++) send_frame(8'h85, 8'h00, 8'h85, 1);
        repeat (4) cycle(1'b0, 8'h00);
        chk("err_count_saturated", 64'(err_count), 64'hFF);

        // Reset mid-frame.
        send_byte(SYNC, 2);
        send_byte(8'h12, 2);
        if (CSUM) send_byte(8'h3C, 2);
        chk("midframe_busy", 64'(busy), 64'd1);
        do_reset();
        chk("after_reset_errcnt", 64'(err_count), 64'd0);
        clr_acc();
        send_byte(CSUM ? 8'h2E : 8'h3C, 8);
        chk("orphan_byte_we", 64'(acc_we), 64'd0);
        chk("orphan_byte_busy", 64'(acc_busy), 64'd0);

        // Randomized frames against the reference model.
        for (int f = 0; f < 300; f++) begin
            kind = $urandom_range(0, 6);
            gap = ($urandom_range(0, 9) == 0) ? $urandom_range(28, 36) : $urandom_range(0, 4);
            data = 8'($urandom);
            case (kind)
                0: cmd = {1'b0, 7'($urandom)};
                1: cmd = 8'h80;
                2: cmd = 8'h81;
                3: cmd = 8'($urandom_range(8'h82, 8'hFF));
                default: cmd = 8'($urandom);
            endcase
            csum = cmd ^ data;
            if (kind == 4) csum = csum ^ 8'($urandom_range(1, 255));
            if (kind == 5) begin
                n = $urandom_range(1, 4);
                for (int j = 0; j < n; j++) send_byte(8'($urandom), $urandom_range(0, 3));
            end else if (kind == 6) begin
                send_byte(SYNC, gap);
                n = $urandom_range(1, FLEN - 1);
                for (int j = 1; j < n; j++) send_byte(8'($urandom), gap);
                repeat (40) cycle(1'b0, 8'h00);
            end else begin
                send_frame(cmd, data, csum, gap);
            end
            k = $urandom_range(0, 3);
            repeat (k) cycle(1'b0, 8'h00);
        end
        repeat (50) cycle(1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
